// File: rtl/gate_bist_pkg.sv
// Shared types and default feedback polynomials for the gate-model BIST controller.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [20:0] POLY_IN_21  = 21'h140000;
    localparam logic [9:0]  POLY_OUT_10 = 10'h240;
    localparam logic [3:0]  POLY_4      = 4'b1001;

endpackage

// File: rtl/gate_bist_lfsr.sv
// Shift register with XOR feedback and parallel input; acts as an LFSR (din = 0) or a MISR.
module gate_bist_lfsr #(
    parameter int unsigned     W    = 4,
    parameter logic [W-1:0]    POLY = 4'b1001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    logic [W-1:0] reg_q;
    logic [W-1:0] reg_d;

    // load wins over en so a new run always starts from a known value
    always_comb begin
        reg_d = reg_q;
        if (load) begin
            reg_d = load_val;
        end else if (en) begin
            reg_d = {reg_q[W-2:0], ^(reg_q & POLY)} ^ din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/gate_model_bist.sv
// BIST controller: LFSR stimulus into an external gate model, MISR compaction of its response,
// and a golden-signature compare once the programmed number of patterns has been applied.
module gate_model_bist
    import gate_bist_pkg::*;
#(
    parameter int unsigned         N_IN     = 21,
    parameter int unsigned         N_OUT    = 10,
    parameter int unsigned         CNT_W    = 16,
    parameter logic [N_IN-1:0]     POLY_IN  = POLY_IN_21,
    parameter logic [N_OUT-1:0]    POLY_OUT = POLY_OUT_10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [N_IN-1:0]  seed,
    input  logic [N_OUT-1:0] golden,
    output logic [N_IN-1:0]  pattern,
    input  logic [N_OUT-1:0] response,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] signature,
    output logic             pass
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;
    logic             run_en;
    logic [N_IN-1:0]  seed_eff;

    // an all-zero seed would lock the LFSR at zero
    assign seed_eff = (seed == '0) ? N_IN'(1) : seed;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        run_en  = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = num_patterns;
                    state_d = (num_patterns != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                run_en = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    gate_bist_lfsr #(
        .W    (N_IN),
        .POLY (POLY_IN)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (seed_eff),
        .en       (run_en),
        .din      ('0),
        .q        (pattern)
    );

    // response of the pattern shown this cycle is absorbed on the same closing edge
    gate_bist_lfsr #(
        .W    (N_OUT),
        .POLY (POLY_OUT)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val ('0),
        .en       (run_en),
        .din      (response),
        .q        (signature)
    );

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign pass = done && (signature == golden);

endmodule

// File: tb/tb_gate_model_bist.sv
// Self-checking bench for gate_model_bist in the 4-in/4-out configuration with a modelled gate.
module tb_gate_model_bist;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 16;
    localparam logic [3:0]  POLY  = 4'b1001;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_patterns;
    logic [N-1:0]     seed;
    logic [N-1:0]     golden;
    logic [N-1:0]     pattern;
    logic [N-1:0]     response;
    logic             busy;
    logic             done;
    logic [N-1:0]     signature;
    logic             pass;

    int checks   = 0;
    int failures = 0;
    int resp_mode = 0;

    always #5 clk = ~clk;

    // Stand-in gate model: mode 0 loops pattern back, mode 1 is a small gate network.
    function automatic logic [3:0] gate_fn(input logic [3:0] p, input int mode);
        if (mode == 0) return p;
        return {p[0] & p[1], p[3] | p[2], p[1] ^ p[3], ~p[0]};
    endfunction

    function automatic logic [3:0] lfsr_step(input logic [3:0] x);
        int v;
        v = ((int'(x) * 2) % 16) + ($countones(x & POLY) % 2);
        return v[3:0];
    endfunction

    function automatic logic [3:0] misr_step(input logic [3:0] m, input logic [3:0] r);
        return lfsr_step(m) ^ r;
    endfunction

    assign response = gate_fn(pattern, resp_mode);

    gate_model_bist #(
        .N_IN     (N),
        .N_OUT    (N),
        .CNT_W    (CNT_W),
        .POLY_IN  (POLY),
        .POLY_OUT (POLY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .seed         (seed),
        .golden       (golden),
        .pattern      (pattern),
        .response     (response),
        .busy         (busy),
        .done         (done),
        .signature    (signature),
        .pass         (pass)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pattern"}, pattern, 0);
        check({tag, "_sig"}, signature, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
    endtask

    // Expected final signature for a complete run.
    function automatic logic [3:0] model_sig(input logic [3:0] s, input int n, input int mode);
        logic [3:0] p, m;
        p = (s == 0) ? 4'd1 : s;
        m = 0;
        for (int k = 0; k < n; k++) begin
            m = misr_step(m, gate_fn(p, mode));
            p = lfsr_step(p);
        end
        return m;
    endfunction

    // Called at a negedge with start low; returns at a negedge in DONE.
    task automatic run_and_check(input logic [3:0] s, input int n, input bit want_pass,
                                 input logic [3:0] alt_golden, input int mode, input string tag);
        logic [3:0] p, m, g;
        m = model_sig(s, n, mode);
        g = want_pass ? m : alt_golden;
        p = (s == 0) ? 4'd1 : s;
        resp_mode    = mode;
        seed         = s;
        num_patterns = CNT_W'(n);
        golden       = g;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            check({tag, "_pat"}, pattern, p);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_done_early"}, done, 0);
            p = lfsr_step(p);
            @(negedge clk);
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_sig"}, signature, m);
        check({tag, "_pass"}, pass, (m == g));
        @(negedge clk);
        check({tag, "_hold_sig"}, signature, m);
        check({tag, "_hold_pat"}, pattern, p);
        check({tag, "_hold_done"}, done, 1);
    endtask

    initial begin
        logic [3:0] exp_seq [15];
        logic [3:0] sig_ref;
        int         busy_cnt;
        exp_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010, 4'b0101,
                    4'b1011, 4'b0110, 4'b1100, 4'b1001, 4'b0010, 4'b0100, 4'b1000};

        rst = 1'b1; start = 1'b0; num_patterns = '0; seed = '0; golden = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_pattern", pattern, 0);
        end

        // LFSR sequence against the listed constants
        resp_mode = 0; seed = 4'b0001; num_patterns = 15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            check("seq_pattern", pattern, exp_seq[k]);
            if (busy) busy_cnt++;
            check("seq_done_early", done, 0);
            @(negedge clk);
        end
        check("seq_busy_cycles", busy_cnt, 15);
        check("seq_done_16", done, 1);
        @(negedge clk);

        // MISR loopback against known signature
        run_and_check(4'b0001, 3, 1'b0, 4'b0111, 0, "loop_pass");
        check("loop_sig_const", signature, 4'b0111);
        check("loop_pass_const", pass, 1);
        run_and_check(4'b0001, 3, 1'b0, 4'b0110, 0, "loop_fail");
        check("loop_nopass_const", pass, 0);

        run_and_check(4'b0101, 0, 1'b1, 4'b0000, 1, "zero_n");
        check("zero_n_sig_const", signature, 0);
        run_and_check(4'b0000, 4, 1'b1, 4'b0000, 1, "seed0");

        // start during RUN is ignored
        sig_ref = model_sig(4'b0110, 5, 1);
        resp_mode = 1; seed = 4'b0110; num_patterns = 5; golden = sig_ref; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        seed = 4'b0011; num_patterns = 9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; seed = 4'b0110; num_patterns = 5;
        for (int c = 3; c <= 5; c++) begin
            check("midstart_busy", busy, 1);
            @(negedge clk);
        end
        check("midstart_done_t6", done, 1);
        check("midstart_sig", signature, sig_ref);
        check("midstart_pass", pass, 1);
        // restart from DONE
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rerun_done_drop", done, 0);
        check("rerun_pass_drop", pass, 0);
        check("rerun_pat1", pattern, 4'b0110);
        repeat (5) @(negedge clk);
        check("rerun_done", done, 1);
        check("rerun_sig", signature, sig_ref);

        // reset mid-RUN
        @(negedge clk);
        resp_mode = 1; seed = 4'b1011; num_patterns = 15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        run_and_check(4'b1011, 15, 1'b1, 4'b0000, 1, "after_rst");

        // randomized runs
        for (int i = 0; i < 24; i++) begin
            run_and_check(4'($urandom), int'($urandom_range(0, 40)), 1'($urandom),
                          4'($urandom), int'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gate_model_bist.md
# gate_model_bist

Parametrised built-in self-test controller for the combinational gate models used in the lab simulator. It drives N_IN pseudo-random stimulus bits into an external gate model from an LFSR and compacts the model's N_OUT response bits into a MISR signature. After a programmable number of patterns it compares the signature against a golden value. It sits between the simulator's test sequencer and any gate model instance, replacing hand-applied input vectors.

## Interface
- N_IN, 21: stimulus width; must be at least 2.
- N_OUT, 10: response and signature width; must be at least 2.
- CNT_W, 16: pattern counter width.
- POLY_IN, 21'h140000 (taps 20,18): LFSR feedback mask, [N_IN-1:0].
- POLY_OUT, 10'h240 (taps 9,6): MISR feedback mask, [N_OUT-1:0].

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- num_patterns  in  CNT_W  number of patterns to apply; sampled with start.
- seed  in  N_IN  LFSR seed; sampled with start. Zero is replaced by 1.
- golden  in  N_OUT  expected signature; compared in DONE.
- pattern  out  N_IN  stimulus to the gate model; equals the LFSR register.
- response  in  N_OUT  gate model outputs; combinational function of pattern.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- signature  out  N_OUT  MISR register.
- pass  out  1  high in DONE when signature == golden.

## Operation
- States:
  - IDLE: entered on reset.
  - RUN: applies patterns.
  - DONE: holds the result until the next start.
- Start in IDLE or DONE:
  - lfsr <= (seed == 0) ? 1 : seed; misr <= 0; cnt <= num_patterns.
  - Next state is RUN if num_patterns != 0, otherwise DONE.
- RUN, every cycle:
  - misr <= {misr[N_OUT-2:0], ^(misr & POLY_OUT)} ^ response.
  - lfsr <= {lfsr[N_IN-2:0], ^(lfsr & POLY_IN)}.
  - cnt <= cnt - 1.
  - Go to DONE when cnt == 1.
- start asserted during RUN is ignored; the run is never restarted mid-way.
- DONE: lfsr, misr and cnt are frozen. pass = (misr == golden), combinational from the registers.
- Reset at any time, including mid-RUN: forces IDLE and clears lfsr, misr, cnt, busy, done and pass to 0. The partial signature is discarded.
- Reset values: pattern 0, busy 0, done 0, signature 0, pass 0.
- Counter arithmetic is unsigned. num_patterns = 2^CNT_W-1 is the maximum run; there is no wrap-around because cnt stops at 1.

## Timing
- start is sampled at edge t. busy is high from t+1 to t+N, where N = num_patterns.
- Pattern k (k = 1..N) is on `pattern` during cycle t+k. Its response is absorbed at the end of that same cycle, so the gate model gets one full cycle of combinational settling.
- done and the final signature are valid from t+N+1.
- Start-to-done latency is N+1 cycles; with N = 0 it is 1 cycle, and the signature is 0.
- A start in DONE at edge u restarts the run: done drops at u+1.
- Throughput is one pattern per cycle; there are no bubbles.

## Structure
- Package gate_bist_pkg:
  - state enum (IDLE, RUN, DONE);
  - default polynomial constants for the 21-input/10-output and 4-bit configurations.
- Sub-module gate_bist_lfsr, parameterised by width W and POLY:
  - ports: clk, rst, load, load_val, en, din, q;
  - next = {q[W-2:0], ^(q & POLY)} ^ din.
- Instantiate gate_bist_lfsr twice: as the LFSR with din = 0, and as the MISR with din = response.
- The FSM and counter live in gate_model_bist.

## Test plan
- Reset, then idle: N_IN = N_OUT = 4, POLY = 4'b1001 -> pattern, signature, busy, done and pass are all 0. No activity for 20 cycles without start.
- LFSR sequence: seed 4'b0001, num_patterns 15 -> pattern runs 0001, 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000; busy is high for exactly 15 cycles and done rises on cycle 16.
- MISR loopback with response = pattern: seed 0001, num_patterns 3, golden 4'b0111 -> signature 0111, pass = 1. Repeat with golden 0110 -> pass = 0.
- Boundary cases:
  - num_patterns 0 -> done 1 cycle after start, busy never set, signature 0.
  - seed 0 -> first pattern is 0001.
- start pulsed during RUN at pattern 2 of 5 -> ignored, and done still arrives 6 cycles after the original start. Then a start in DONE -> clean rerun with identical signature.
- rst asserted mid-RUN at pattern 7 of 15 -> next cycle: IDLE, all outputs 0. A following start produces the same signature as an uninterrupted run.
